vip_featuremap_col3_feeder: RTL
===============================

# vip_featuremap_col3_feeder

Producer side of the conv2d 3x3 engine input FIFO. It accepts a raster-order stream of feature-map pixels, one DWIDTH word per transfer. Using two line buffers, it emits one packed vertical 3-pixel column per input pixel once two full rows are primed. Output drives the engine top's `fifo_in_data` / `fifo_in_wrreq` / `fifo_in_full` port directly.

## Interface
Parameters:
- DWIDTH, 32, pixel word width
- IMG_W, 112, pixels per row
- IMG_H, 112, rows per frame (IMG_W*IMG_H = 12544 matches the engine input FIFO depth)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pix_data  in  DWIDTH  input pixel, raster order, row-major
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  feeder can accept; transfer occurs when pix_valid && pix_ready
- fifo_in_data  out  3*DWIDTH  packed column {row r-2, row r-1, row r}; row r-2 occupies [3*DWIDTH-1:2*DWIDTH], row r occupies [DWIDTH-1:0]
- fifo_in_wrreq  out  1  one-cycle write strobe to the engine input FIFO
- fifo_in_full  in  1  engine input FIFO full/almost-full
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters: `col` 0..IMG_W-1, `row` 0..IMG_H-1, both advanced on accept only. `col` wraps to 0 and increments `row` at IMG_W-1.
- Line buffers: lb0 holds row r-2 and lb1 holds row r-1. Each is IMG_W words with asynchronous read.
  - On accept at `col`: capture lb0[col], lb1[col] and pix_data, then write lb0[col] <= lb1[col] and lb1[col] <= pix_data (shift-through).
- FSM:
  - PRIME (rows 0,1): accept whenever pix_valid. No output. Go to STREAM on accepting row 1, col IMG_W-1.
  - STREAM (rows 2..IMG_H-1): pix_ready = !fifo_in_full. Each accept registers the packed column and asserts fifo_in_wrreq the next cycle. Go to DONE on accepting row IMG_H-1, col IMG_W-1.
  - DONE: single cycle. pix_ready=0, frame_done=1, counters cleared. Go to PRIME.
- Output words per frame: (IMG_H-2)*IMG_W, which is 12320 at default parameters.
- Line-buffer contents are not cleared between frames. PRIME overwrites them before any use.

## Timing
- Reset values: pix_ready=0, fifo_in_wrreq=0, fifo_in_data=0, frame_done=0, FSM=PRIME, col=row=0.
- First cycle after reset release: pix_ready=1.
- Latency: accept in cycle N produces fifo_in_wrreq/fifo_in_data in cycle N+1. Throughput is one word per cycle.
- fifo_in_full is sampled combinationally into pix_ready. fifo_in_full rising in the same cycle as an accept still allows the write in N+1; the engine's almost_full margin absorbs it.
- pix_ready is combinational from the FSM state and fifo_in_full only, never from pix_valid.
- fifo_in_wrreq is never asserted in PRIME or DONE, nor for any cycle without a preceding accept.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). An in-flight wrreq is dropped and the next frame restarts at row 0.
- pix_valid held high across frames: the DONE cycle inserts exactly one bubble.

## Structure
- Shared package `vip_featuremap_pkg`: FSM state encoding (PRIME, STREAM, DONE), default IMG_W/IMG_H/DWIDTH constants, counter width as $clog2(IMG_W) and $clog2(IMG_H).
- One sub-module `vip_line_buffer` (IMG_W x DWIDTH, async read, sync write, no reset on storage), instantiated twice. Counters, FSM and output register stay in the top.
- Target size: about 180 lines of RTL.

## Test plan
Use IMG_W=4, IMG_H=4, pixel value = row*16+col, DWIDTH=8 unless stated.
- Continuous stream, fifo_in_full=0: exactly 8 wrreq pulses. The first carries 0x001020, the last carries 0x132333. frame_done pulses once, one cycle after the accept of 0x33.
- fifo_in_full forced high at the 3rd STREAM accept for 5 cycles: pix_ready=0 for those 5 cycles. No accept occurs and no extra wrreq is issued beyond the single in-flight word. The sequence resumes without a gap or duplicate.
- pix_valid toggled randomly at 50%: the output sequence is identical to the continuous case and the word count is still 8.
- Reset asserted at row 2, col 1: all outputs go to 0 within the reset assertion. A new frame then yields first word 0x001020 with no stale words.
- Two back-to-back frames, the second offset by +0x40: 16 wrreq total. The 9th word is 0x405060, proving no leakage from frame 1. One bubble occurs at the frame boundary.
- Default parameters (112x112, DWIDTH=32), random full backpressure: 12320 words, all matching a reference column model.

Source files
------------

// File: rtl/vip_featuremap_pkg.sv
// Shared types and defaults for the feature-map column feeder.
// Latency: n/a (constants, state encoding and a width helper only).
// Backpressure: n/a.
package vip_featuremap_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_IMG_W  = 112;
    localparam int DEF_IMG_H  = 112;

    // Counter widths at the default geometry.
    localparam int DEF_COL_W  = $clog2(DEF_IMG_W);
    localparam int DEF_ROW_W  = $clog2(DEF_IMG_H);

    // Feeder FSM encoding.
    localparam logic [1:0] ST_PRIME  = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vip_line_buffer.sv
// One image row of pixel storage, indexed by column.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; the caller gates i_wr_en with its own accept.
module vip_line_buffer #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 112,
    parameter int AW     = 7
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    assign o_rd_data = r_mem[i_addr];

    // Storage is never reset: priming rows overwrite every entry before it is read.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/vip_featuremap_col3_feeder.sv
// Turns a raster pixel stream into packed 3-row vertical columns for the conv2d input FIFO.
// Latency: accept in cycle N gives fifo_in_wrreq/fifo_in_data in cycle N+1, one word per cycle.
// Backpressure: pix_ready drops combinationally on fifo_in_full while streaming, and in the DONE cycle.
module vip_featuremap_col3_feeder
    import vip_featuremap_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DWIDTH-1:0]   pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [3*DWIDTH-1:0] fifo_in_data,
    output logic                fifo_in_wrreq,
    input  logic                fifo_in_full,
    output logic                frame_done
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRIME_LAST = RW'(1);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [3*DWIDTH-1:0] r_data;
    logic                r_wrreq;

    logic                w_accept;
    logic                w_col_last;
    logic                w_row_last;
    logic [DWIDTH-1:0]   w_lb0_rd;
    logic [DWIDTH-1:0]   w_lb1_rd;

    assign w_accept   = pix_valid && pix_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    assign fifo_in_data  = r_data;
    assign fifo_in_wrreq = r_wrreq;
    assign frame_done    = (r_state == ST_DONE);

    // Ready depends on state and FIFO fullness only; held low while reset is asserted.
    always_comb begin
        pix_ready = 1'b0;
        if (reset) begin
            case (r_state)
                ST_PRIME:  pix_ready = 1'b1;
                ST_STREAM: pix_ready = !fifo_in_full;
                default:   pix_ready = 1'b0;
            endcase
        end
    end

    // lb0 holds row r-2, lb1 holds row r-1; each accept shifts the column down one row.
    vip_line_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_W),
        .AW     (CW)
    ) u_lb0 (
        .clock     (clock),
        .i_wr_en   (w_accept),
        .i_addr    (r_col),
        .i_wr_data (w_lb1_rd),
        .o_rd_data (w_lb0_rd)
    );

    vip_line_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_W),
        .AW     (CW)
    ) u_lb1 (
        .clock     (clock),
        .i_wr_en   (w_accept),
        .i_addr    (r_col),
        .i_wr_data (pix_data),
        .o_rd_data (w_lb1_rd)
    );

    // Frame sequencing: prime two rows, stream the rest, then one DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_PRIME;
        end else begin
            case (r_state)
                ST_PRIME: begin
                    if (w_accept && (r_row == ROW_PRIME_LAST) && w_col_last) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept && w_row_last && w_col_last) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_PRIME;
            endcase
        end
    end

    // Raster position, advanced on accept; DONE returns it to the frame origin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == ST_DONE) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Output register: one packed column per streaming accept, row r-2 in the top slice.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_wrreq <= 1'b0;
        end else begin
            r_wrreq <= w_accept && (r_state == ST_STREAM);
            if (w_accept && (r_state == ST_STREAM)) begin
                r_data <= {w_lb0_rd, w_lb1_rd, pix_data};
            end
        end
    end

endmodule
